word_aligner: RTL and testbench



---
 rtl/word_align_pkg.sv | 21 ++
 rtl/word_align_fsm.sv | 97 +++++++++
 rtl/word_aligner.sv | 72 +++++++
 tb/tb_word_aligner.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_align_pkg.sv
// word_align_pkg -- shared types, default sync pattern and phase saturation.
// Rev 1.0
`default_nettype none

package word_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hBC;

  function automatic int sat_phase(input int p, input int width);
    return (p >= width) ? width - 1 : p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_align_fsm.sv
// word_align_fsm -- hunt/verify/lock sequencer owning the bit phase.
// Rev 1.0
`default_nettype none

module word_align_fsm
  import word_align_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  localparam int PW      = $clog2(WIDTH),
  localparam int CW      = $clog2(LOCK_CNT + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          boundary,
  input  logic          match,
  input  logic          manual,
  input  logic [PW-1:0] phase_in,
  input  logic          realign,
  output logic [PW-1:0] phase,
  output logic          locked
);

  state_t        state, state_n;
  logic [CW-1:0] mcnt, mcnt_n;
  logic [PW-1:0] phase_n, phase_inc;
  logic          pend, pend_n;

  assign phase_inc = (phase == PW'(WIDTH - 1)) ? '0 : phase + PW'(1);
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= HUNT;
      mcnt  <= '0;
      phase <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      mcnt  <= mcnt_n;
      phase <= phase_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    mcnt_n  = mcnt;
    phase_n = phase;
    // A realign request waits for the next word boundary; manual mode drops it.
    pend_n  = (pend | realign) & ~manual;
    if (boundary) begin
      pend_n = 1'b0;
      if (manual) begin
        state_n = HUNT;
        mcnt_n  = '0;
        phase_n = PW'(sat_phase(32'(phase_in), WIDTH));
      end else if (pend | realign) begin
        state_n = HUNT;
        mcnt_n  = '0;
      end else begin
        case (state)
          HUNT: begin
            if (match) begin
              if (LOCK_CNT == 1) begin
                state_n = LOCKED;
              end else begin
                state_n = VERIFY;
              end
              mcnt_n = CW'(1);
            end else begin
              phase_n = phase_inc;
            end
          end
          VERIFY: begin
            if (match) begin
              mcnt_n = mcnt + CW'(1);
              if (int'(mcnt) + 1 >= LOCK_CNT) state_n = LOCKED;
            end else begin
              state_n = HUNT;
              mcnt_n  = '0;
              phase_n = phase_inc;
            end
          end
          LOCKED:  ;
          default: begin
            state_n = HUNT;
            mcnt_n  = '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/word_aligner.sv
// word_aligner -- serial-to-parallel deserialiser with automatic sync alignment.
// Rev 1.0
`default_nettype none

module word_aligner
  import word_align_pkg::*;
#(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] SYNC   = WIDTH'(SYNC_DEFAULT),
  parameter int             LOCK_CNT = 4,
  localparam int            PW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in,
  input  logic             manual,
  input  logic [PW-1:0]    phase_in,
  input  logic             realign,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [PW-1:0]    phase_out,
  output logic             locked,
  output logic             sync_match
);

  // The topmost history bit can never fall inside a window, so it is not stored.
  logic [2*WIDTH-3:0] sr;
  logic [2*WIDTH-2:0] sr_n;
  logic [WIDTH-1:0]   win;
  logic [PW-1:0]      bcnt;
  logic               boundary;
  logic               match;

  assign sr_n     = {sr, in};
  assign win      = sr_n[phase_out +: WIDTH];
  assign boundary = (bcnt == PW'(WIDTH - 1));
  assign match    = (win == SYNC);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sr         <= '0;
      bcnt       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync_match <= 1'b0;
    end else begin
      sr         <= sr_n[2*WIDTH-3:0];
      bcnt       <= boundary ? '0 : bcnt + PW'(1);
      data_valid <= boundary;
      sync_match <= boundary & match;
      if (boundary) data_out <= win;
    end
  end

  word_align_fsm #(
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT)
  ) u_fsm (
    .clk      (clk),
    .rstn     (rstn),
    .boundary (boundary),
    .match    (match),
    .manual   (manual),
    .phase_in (phase_in),
    .realign  (realign),
    .phase    (phase_out),
    .locked   (locked)
  );

endmodule

`default_nettype wire

// File: tb/tb_word_aligner.sv
// tb_word_aligner -- randomized self-checking bench against a bit-history reference model.
// Rev 1.0
`default_nettype none

module tb_word_aligner;

  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hBC;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in = 1'b0;
  logic       manual = 1'b0;
  logic       realign = 1'b0;
  logic [2:0] phase_in = 3'd0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [2:0] phase_out;
  logic       locked;
  logic       sync_match;

  logic [7:0] sy = SYNC;

  always #5 clk = ~clk;

  word_aligner #(.WIDTH(W), .SYNC(SYNC), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in         (in),
    .manual     (manual),
    .phase_in   (phase_in),
    .realign    (realign),
    .data_out   (data_out),
    .data_valid (data_valid),
    .phase_out  (phase_out),
    .locked     (locked),
    .sync_match (sync_match)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: full bit history since reset, word boundaries every W bits.
  bit         hist[$];
  int         m_bcnt, m_phase, m_cnt, m_nb;
  bit         m_locked, m_pend;
  logic [7:0] exp_data;
  bit         exp_valid, exp_match;

  function automatic logic [7:0] word_ending_at(int e);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      int idx = e - 7 + i;
      w[7-i] = (idx >= 0 && idx < hist.size()) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic tick(input logic b, input logic ra);
    logic       man_s, rn_s;
    logic [2:0] pin_s;
    in      = b;
    realign = ra;
    man_s   = manual;
    rn_s    = rstn;
    pin_s   = phase_in;
    @(posedge clk);
    if (!rn_s) begin
      hist.delete();
      m_bcnt = 0; m_phase = 0; m_cnt = 0; m_nb = 0;
      m_locked = 0; m_pend = 0;
      exp_data = 8'h00; exp_valid = 0; exp_match = 0;
    end else begin
      hist.push_back(b);
      exp_valid = (m_bcnt == W - 1);
      exp_match = 0;
      if (exp_valid) begin
        exp_data  = word_ending_at(hist.size() - 1 - m_phase);
        exp_match = (exp_data == SYNC);
        m_nb++;
        if (man_s) begin
          m_phase  = (int'(pin_s) < W) ? int'(pin_s) : W - 1;
          m_cnt    = 0;
          m_locked = 0;
        end else if (m_pend || ra) begin
          m_cnt    = 0;
          m_locked = 0;
        end else if (!m_locked) begin
          if (exp_match) begin
            m_cnt++;
            if (m_cnt >= 4) m_locked = 1;
          end else begin
            m_cnt   = 0;
            m_phase = (m_phase + 1) % W;
          end
        end
        m_pend = 0;
      end else begin
        m_pend = (m_pend || ra) && !man_s;
      end
      m_bcnt = (m_bcnt + 1) % W;
    end
    #1;
    realign = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(1'($urandom), 1'b0);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'($urandom), 1'b0);
    rstn = 1'b0;
    tick(1'($urandom), 1'b0);
    n_checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || sync_match !== 1'b0 ||
        locked !== 1'b0 || phase_out !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h valid=%b match=%b locked=%b phase=%0d, required all zero",
               data_out, data_valid, sync_match, locked, phase_out);
    end
    rstn  = 1'b1;
    first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      tick(1'($urandom), 1'b0);
      if (data_valid === 1'b1) first = i;
    end
    n_checks++;
    if (first != 8) begin
      n_fail++;
      $display("FAIL first_valid_edge: got edge %0d after release, required 8", first);
    end
  endtask

  task automatic test_auto_lock();
    do_reset();
    for (int n = 0; n < 3 + 12 * 8; n++) begin
      tick((n < 3) ? 1'b0 : sy[7 - (n - 3) % 8], 1'b0);
      n_checks++;
      if (data_valid !== exp_valid || locked !== m_locked || phase_out !== 3'(m_phase) ||
          sync_match !== exp_match || (exp_valid && data_out !== exp_data)) begin
        n_fail++;
        $display("FAIL auto_lock_model: valid=%b/%b locked=%b/%b phase=%0d/%0d match=%b/%b data=%h/%h",
                 data_valid, exp_valid, locked, m_locked, phase_out, m_phase, sync_match, exp_match,
                 data_out, exp_data);
      end
      if (exp_valid && m_nb == 8) begin
        n_checks++;
        if (locked !== 1'b0) begin
          n_fail++;
          $display("FAIL auto_lock_early: locked=%b after boundary 8, required 0", locked);
        end
      end
      if (exp_valid && m_nb == 9) begin
        n_checks++;
        if (locked !== 1'b1 || phase_out !== 3'd5) begin
          n_fail++;
          $display("FAIL auto_lock_acquire: locked=%b phase=%0d, required locked=1 phase=5",
                   locked, phase_out);
        end
      end
      if (exp_valid && m_nb > 9) begin
        n_checks++;
        if (data_out !== SYNC) begin
          n_fail++;
          $display("FAIL auto_lock_data: data=%h, required %h", data_out, SYNC);
        end
      end
    end
  endtask

  task automatic test_verify_fail();
    do_reset();
    for (int n = 0; n < 16; n++) tick(sy[7 - n % 8], 1'b0);
    for (int n = 0; n < 8; n++) tick(1'b0, 1'b0);
    n_checks++;
    if (locked !== 1'b0 || phase_out !== 3'd1) begin
      n_fail++;
      $display("FAIL verify_drop: locked=%b phase=%0d, required locked=0 phase=1", locked, phase_out);
    end
    for (int n = 0; n < 14 * 8; n++) begin
      tick(sy[7 - n % 8], 1'b0);
      n_checks++;
      if (data_valid !== exp_valid || locked !== m_locked || phase_out !== 3'(m_phase) ||
          sync_match !== exp_match || (exp_valid && data_out !== exp_data)) begin
        n_fail++;
        $display("FAIL verify_model: valid=%b/%b locked=%b/%b phase=%0d/%0d match=%b/%b data=%h/%h",
                 data_valid, exp_valid, locked, m_locked, phase_out, m_phase, sync_match, exp_match,
                 data_out, exp_data);
      end
    end
    n_checks++;
    if (locked !== 1'b1 || phase_out !== 3'd0) begin
      n_fail++;
      $display("FAIL verify_relock: locked=%b phase=%0d, required locked=1 phase=0", locked, phase_out);
    end
  endtask

  // Continues from the locked, phase-0, word-aligned state left by test_verify_fail.
  task automatic test_lock_hold();
    for (int n = 0; n < 50 * 8; n++) begin
      tick(1'($urandom), 1'b0);
      n_checks++;
      if (data_valid !== exp_valid || locked !== 1'b1 || phase_out !== 3'd0 ||
          sync_match !== exp_match || (exp_valid && data_out !== exp_data)) begin
        n_fail++;
        $display("FAIL lock_hold: valid=%b/%b locked=%b/1 phase=%0d/0 match=%b/%b data=%h/%h",
                 data_valid, exp_valid, locked, phase_out, sync_match, exp_match, data_out, exp_data);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'($urandom), i == 3);
      n_checks++;
      if (i < 7) begin
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL realign_pending: locked=%b before boundary, required 1", locked);
        end
      end else if (locked !== 1'b0 || phase_out !== 3'd0 || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL realign_apply: locked=%b phase=%0d valid=%b, required locked=0 phase=0 valid=1",
                 locked, phase_out, data_valid);
      end
    end
  endtask

  task automatic test_manual();
    do_reset();
    manual   = 1'b1;
    phase_in = 3'd7;
    for (int n = 0; n < 1 + 14 * 8; n++) begin
      if (m_nb == 8) manual = 1'b0;
      tick((n < 1) ? 1'b0 : sy[7 - (n - 1) % 8], 1'b0);
      if (exp_valid && m_nb == 1) begin
        n_checks++;
        if (phase_out !== 3'd7 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL manual_phase: phase=%0d locked=%b, required phase=7 locked=0", phase_out, locked);
        end
      end
      if (exp_valid && m_nb >= 2 && m_nb <= 8) begin
        n_checks++;
        if (sync_match !== 1'b1 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL manual_match: match=%b locked=%b, required match=1 locked=0", sync_match, locked);
        end
      end
    end
    n_checks++;
    if (locked !== 1'b1 || phase_out !== 3'd7) begin
      n_fail++;
      $display("FAIL manual_release_lock: locked=%b phase=%0d, required locked=1 phase=7", locked, phase_out);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 1 + 12 * 8; n++) tick((n < 1) ? 1'b0 : sy[7 - (n - 1) % 8], 1'b0);
    n_checks++;
    if (locked !== 1'b1 || phase_out !== 3'd7) begin
      n_fail++;
      $display("FAIL wrap_up_to_7: locked=%b phase=%0d, required locked=1 phase=7", locked, phase_out);
    end
    do_reset();
    manual   = 1'b1;
    phase_in = 3'd7;
    for (int n = 0; n < 8 * 8; n++) begin
      tick(sy[7 - n % 8], 1'b0);
      if (m_nb == 1) manual = 1'b0;
      if (exp_valid && m_nb == 2) begin
        n_checks++;
        if (phase_out !== 3'd0 || locked !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_7_to_0: phase=%0d locked=%b, required phase=0 locked=0", phase_out, locked);
        end
      end
    end
    n_checks++;
    if (locked !== 1'b1 || phase_out !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_relock_0: locked=%b phase=%0d, required locked=1 phase=0", locked, phase_out);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int k;
      manual = 1'b0;
      do_reset();
      k = $urandom_range(0, 7);
      for (int c = 0; c < 700; c++) begin
        logic b;
        b = (c < k) ? 1'b0 : sy[7 - (c - k) % 8];
        if ($urandom_range(0, 60) == 0) b = ~b;
        if ($urandom_range(0, 150) == 0) begin
          manual   = ~manual;
          phase_in = 3'($urandom);
        end
        tick(b, $urandom_range(0, 120) == 0);
        n_checks++;
        if (data_valid !== exp_valid || locked !== m_locked || phase_out !== 3'(m_phase) ||
            sync_match !== exp_match || (exp_valid && data_out !== exp_data)) begin
          n_fail++;
          $display("FAIL random_model: it=%0d c=%0d valid=%b/%b locked=%b/%b phase=%0d/%0d match=%b/%b data=%h/%h",
                   it, c, data_valid, exp_valid, locked, m_locked, phase_out, m_phase,
                   sync_match, exp_match, data_out, exp_data);
        end
      end
    end
    manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_lock();
    test_verify_fail();
    test_lock_hold();
    test_manual();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
